// File: rtl/bios_arb_pkg.sv
// Shared types and width defaults for the BIOS read-port arbiter.
package bios_arb_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DLOAD  = 1'b1
  } port_id_e;

  // Outstanding-read tag: captured on grant, consumed by the response demux.
  typedef struct packed {
    logic     vld;
    port_id_e id;
    logic     err;
  } tag_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/bios_port_arbiter_if.sv
// Request/response/memory signal bundle between the two requesters, the arbiter and BIOS memory.
interface bios_port_arbiter_if;
  import bios_arb_pkg::*;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  mem_en, mem_addr
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, mem_rdata,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output mem_en, mem_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant logic. BIOS_ARB_RR_EN selects round-robin; default is fixed
// priority with port 1 (data load) winning.
module rr_arb2
  import bios_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef BIOS_ARB_RR_EN
  port_id_e last_q, last_d;
  logic     win1;

  // last_q is the most recent winner; on conflict the other port goes next.
  always_comb begin
    win1   = req1 & (~req0 | (last_q == PORT_IFETCH));
    gnt1   = rst_n & win1;
    gnt0   = rst_n & req0 & ~win1;
    last_d = last_q;
    if (gnt1) begin
      last_d = PORT_DLOAD;
    end else if (gnt0) begin
      last_d = PORT_IFETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_IFETCH;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    gnt1 = rst_n & req1;
    gnt0 = rst_n & req0 & ~req1;
  end
`endif

endmodule

// File: rtl/bios_port_arbiter.sv
// Shares one synchronous-read BIOS memory port between fetch (port 0) and load (port 1).
// Optional round-robin arbitration via BIOS_ARB_RR_EN (see rr_arb2).
module bios_port_arbiter
  import bios_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bios_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic              gnt0, gnt1, issue;
  logic [ADDR_W-1:0] sel_addr, mem_addr_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  tag_t              tag_d, tag_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (bus.req0_valid),
    .req1  (bus.req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    issue     = gnt0 | gnt1;
    sel_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
    tag_d.vld = issue;
    tag_d.id  = gnt1 ? PORT_DLOAD : PORT_IFETCH;
    tag_d.err = issue & misaligned(sel_addr[1:0]);
  end

  always_comb begin
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.mem_en     = issue;
    bus.mem_addr   = issue ? sel_addr : mem_addr_q;

    bus.rsp0_valid = tag_q.vld & (tag_q.id == PORT_IFETCH);
    bus.rsp1_valid = tag_q.vld & (tag_q.id == PORT_DLOAD);
    bus.rsp0_err   = bus.rsp0_valid & tag_q.err;
    bus.rsp1_err   = bus.rsp1_valid & tag_q.err;
    // Read data passes straight through on the response cycle, then is held.
    bus.rsp0_data  = bus.rsp0_valid ? bus.mem_rdata : rsp0_data_q;
    bus.rsp1_data  = bus.rsp1_valid ? bus.mem_rdata : rsp1_data_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.req0_valid && bus.req1_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      mem_addr_q  <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      tag_q       <= tag_d;
      mem_addr_q  <= bus.mem_addr;
      rsp0_data_q <= bus.rsp0_data;
      rsp1_data_q <= bus.rsp1_data;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Randomized bench for bios_port_arbiter with a transaction-level reference model.
module tb_bios_port_arbiter;
  import bios_arb_pkg::*;

  localparam int unsigned SMALL_W = 4;
  localparam int unsigned SMALL_MAX = (1 << SMALL_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bios_port_arbiter_if bus ();
  bios_port_arbiter_if bus_s ();
  logic [15:0]        cnt;
  logic [SMALL_W-1:0] cnt_s;

  bios_port_arbiter #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (cnt)
  );

  // Narrow-counter copy, fed the same traffic, to reach saturation quickly.
  bios_port_arbiter #(.CNT_W(SMALL_W)) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_s),
    .conflict_cnt (cnt_s)
  );

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_addr  = bus.req0_addr;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_addr  = bus.req1_addr;
  assign bus_s.mem_rdata  = bus.mem_rdata;

  logic [DATA_W-1:0] mem_words [1024];

  // Synchronous-read memory; garbage on idle cycles.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem_words[bus.mem_addr[11:2]];
    else            bus.mem_rdata <= $urandom();
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic              exp_pend = 1'b0;
  int                exp_id = 0;
  logic              exp_err = 1'b0;
  int                exp_idx = 0;
  logic [ADDR_W-1:0] exp_maddr = '0;
  logic [DATA_W-1:0] exp_d0 = '0, exp_d1 = '0;
  int                exp_cnt = 0, exp_cnt_s = 0;
  int                last = 0;
  int                gnt_log[$];

  always @(negedge clk) begin
    int g;
    if (!rst_n) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_rsp0_valid", bus.rsp0_valid, 0);
      check("rst_rsp1_valid", bus.rsp1_valid, 0);
      check("rst_cnt", cnt, 0);
      check("rst_cnt_s", cnt_s, 0);
      exp_pend = 1'b0; exp_cnt = 0; exp_cnt_s = 0; last = 0;
      exp_maddr = '0; exp_d0 = '0; exp_d1 = '0;
    end else begin
      if (exp_pend) begin
        if (exp_id == 0) exp_d0 = mem_words[exp_idx];
        else             exp_d1 = mem_words[exp_idx];
      end
      check("rsp0_valid", bus.rsp0_valid, exp_pend && exp_id == 0);
      check("rsp1_valid", bus.rsp1_valid, exp_pend && exp_id == 1);
      check("rsp0_err", bus.rsp0_err, exp_pend && exp_id == 0 && exp_err);
      check("rsp1_err", bus.rsp1_err, exp_pend && exp_id == 1 && exp_err);
      check("rsp0_data", bus.rsp0_data, exp_d0);
      check("rsp1_data", bus.rsp1_data, exp_d1);
      check("conflict_cnt", cnt, exp_cnt);
      check("conflict_cnt_s", cnt_s, exp_cnt_s);

      g = -1;
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef BIOS_ARB_RR_EN
        g = 1 - last;
`else
        g = 1;
`endif
      end else if (bus.req1_valid) g = 1;
      else if (bus.req0_valid)     g = 0;

      check("req0_ready", bus.req0_ready, g == 0);
      check("req1_ready", bus.req1_ready, g == 1);
      check("mem_en", bus.mem_en, g >= 0);
      if (g >= 0) begin
        exp_maddr = (g == 1) ? bus.req1_addr : bus.req0_addr;
        last = g;
        gnt_log.push_back(g);
      end
      check("mem_addr", bus.mem_addr, exp_maddr);

      exp_pend = (g >= 0);
      exp_id   = g;
      exp_err  = (exp_maddr[1:0] != 2'b00);
      exp_idx  = int'(exp_maddr[11:2]);
      if (bus.req0_valid && bus.req1_valid) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt_s < int'(SMALL_MAX)) exp_cnt_s++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0,
                       input logic v1, input logic [ADDR_W-1:0] a1);
    bus.req0_valid = v0; bus.req0_addr = a0;
    bus.req1_valid = v1; bus.req1_addr = a1;
  endtask

  initial begin
    int exp_seq[4];
    for (int i = 0; i < 1024; i++) mem_words[i] = $urandom();
    mem_words[4] = 32'hDEADBEEF;
`ifdef BIOS_ARB_RR_EN
    exp_seq = '{1, 0, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1};
`endif

    // Reset held with both requests asserted
    rst_n = 1'b0;
    drive(1'b1, 12'h100, 1'b1, 12'h200);
    repeat (3) next_cycle();
    check("lit_rst_ready0", bus.req0_ready, 0);
    check("lit_rst_cnt", cnt, 0);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0);

    // Single fetch
    next_cycle();
    drive(1'b1, 12'h010, 1'b0, '0);
    #2 check("lit_fetch_ready", bus.req0_ready, 1);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    check("lit_fetch_rsp_valid", bus.rsp0_valid, 1);
    check("lit_fetch_rsp_data", bus.rsp0_data, 32'hDEADBEEF);
    check("lit_fetch_rsp1_quiet", bus.rsp1_valid, 0);

    // Four conflict cycles
    next_cycle();
    gnt_log.delete();
    drive(1'b1, 12'h100, 1'b1, 12'h200);
    repeat (4) next_cycle();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    check("lit_conf_grants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      check("lit_conf_grant_seq", gnt_log[i], exp_seq[i]);
    end
    check("lit_conf_cnt", cnt, 4);

    // Misaligned load
    next_cycle();
    drive(1'b0, '0, 1'b1, 12'h006);
    #2;
    check("lit_mis_mem_addr", bus.mem_addr, 12'h006);
    check("lit_mis_ready1", bus.req1_ready, 1);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    check("lit_mis_rsp_valid", bus.rsp1_valid, 1);
    check("lit_mis_rsp_err", bus.rsp1_err, 1);
    check("lit_mis_rsp_data", bus.rsp1_data, mem_words[1]);

    // Back-to-back fetches
    next_cycle();
    drive(1'b1, 12'h000, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i < 2) drive(1'b1, ADDR_W'(4 * (i + 1)), 1'b0, '0);
      else       drive(1'b0, '0, 1'b0, '0);
      #2;
      check("lit_b2b_valid", bus.rsp0_valid, 1);
      check("lit_b2b_data", bus.rsp0_data, mem_words[i]);
    end

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 2) != 0), ADDR_W'($urandom()),
            1'($urandom_range(0, 2) != 0), ADDR_W'($urandom()));
    end
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0);

    // Reset the cycle after a grant: response dropped, counter cleared
    next_cycle();
    drive(1'b1, 12'h020, 1'b1, 12'h024);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    #2;
    check("lit_midrst_rsp0", bus.rsp0_valid, 0);
    check("lit_midrst_rsp1", bus.rsp1_valid, 0);
    check("lit_midrst_cnt", cnt, 0);
    next_cycle();
    rst_n = 1'b1;

    // Counter saturation
    next_cycle();
    drive(1'b1, 12'h100, 1'b1, 12'h204);
    repeat (20) next_cycle();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    check("lit_sat_cnt_s", cnt_s, SMALL_MAX);
    check("lit_sat_cnt", cnt, 20);

    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
